trng_cond_sequencer: RTL and testbench
======================================

# trng_cond_sequencer

Cycle-level sequencer for the TRNG conditioning datapath. It accepts a start pulse and an operation type, then drives the datapath mux selects, register clear/enable strobes and the SHA core start/done handshake to run 0–3 chained hash passes over the raw entropy word. It adds a hash-completion watchdog with an error flag. It sits between the TRNG top-level command interface and the conditioning datapath, replacing hand-sequenced control.

## Interface
- P_TIMEOUT, 1023: max cycles spent in WAIT for Hash_done before error (≥1).
- P_TO_WIDTH, 10: watchdog counter width; must hold P_TIMEOUT.

- clk  in  1  single clock; all logic rising-edge.
- Reset  in  1  synchronous, active-high reset.
- TRNG_Go  in  1  start request; sampled only in IDLE.
- Op_Type  in  2  0=INIT (clear), 1=COND_1, 2=COND_2, 3=COND_3 (number of hash passes).
- TRNG_Done  out  1  one-cycle completion pulse.
- TRNG_Busy  out  1  high in every state except IDLE.
- TRNG_Err  out  1  watchdog error flag; level.
- mux1_sel  out  1  hash message source: 0=data_in, 1=chained digest (reg_2).
- mux2_sel  out  1  0=full data_in message, 1=digest in upper half, data_in lower half.
- Hash_Go  out  1  one-cycle SHA start pulse.
- Hash_done  in  1  SHA completion; honoured only in WAIT.
- rst_reg_1, rst_reg_2  out  1  one-cycle clear strobes for message/digest registers.
- en_reg_1  out  1  message register load enable.
- en_reg_2  out  1  digest register load enable.

## Operation
- States: IDLE, CLR, LOAD, HASH, WAIT, CAPT, DONE.
- IDLE: TRNG_Go=1 latches Op_Type into op_q, sets pass counter k=1, clears TRNG_Err. Next state is CLR if Op_Type=0, else LOAD.
- CLR: rst_reg_1=rst_reg_2=1 for one cycle → DONE.
- LOAD: en_reg_1=1. mux1_sel=mux2_sel=(k≠1) → HASH.
- HASH: Hash_Go=1, mux selects held, watchdog cleared → WAIT.
- WAIT: mux selects held. Hash_done=1 → CAPT. Otherwise the watchdog increments; when the count reaches P_TIMEOUT, the block pulses rst_reg_1=rst_reg_2=1 for one cycle, sets TRNG_Err, and returns to IDLE with no TRNG_Done.
- CAPT: en_reg_2=1. If k==op_q → DONE, else k←k+1 → LOAD.
- DONE: TRNG_Done=1 → IDLE.
- Boundary rules:
  - TRNG_Go while Busy is ignored, not queued.
  - Hash_done outside WAIT is ignored.
  - If Hash_done arrives in the same cycle the watchdog would expire, done wins.
  - Op_Type changes after acceptance have no effect.
  - TRNG_Err persists until the next accepted TRNG_Go or Reset.
  - Reset mid-operation returns to IDLE next edge with no Hash_Go, TRNG_Done or reg strobes issued in that cycle. SHA core state is the caller's concern.

## Timing
- Reset values: all outputs 0, state IDLE, k=0, op_q=0, watchdog=0, TRNG_Err=0.
- All outputs are registered-state decodes: Moore, no combinational path from inputs to outputs.
- Go sampled at edge in cycle 0 → first non-IDLE state in cycle 1.
- INIT: CLR cycle 1, TRNG_Done cycle 2.
- COND_n with hash latency L (Hash_done high L cycles after the Hash_Go cycle, L≥1): each pass is L+3 cycles (LOAD, HASH, L×WAIT, CAPT). TRNG_Done is high in cycle 1+n·(L+3). Busy is high cycles 1..1+n·(L+3).
- Timeout: the error-path reset strobes and TRNG_Err rise P_TIMEOUT+1 cycles after the Hash_Go cycle, then the block returns to IDLE.
- Back-to-back: Go high in the cycle after DONE is accepted; minimum one IDLE cycle between operations.

## Test plan
- Reset, then Go with Op_Type=0 → rst_reg_1/2 pulse in cycle 1, TRNG_Done in cycle 2, no Hash_Go.
- Op_Type=1, Hash_done model L=4 → one Hash_Go with mux1_sel=0, en_reg_2 in cycle 7, TRNG_Done in cycle 8.
- Op_Type=3, L=2 → three Hash_Go pulses; mux1_sel/mux2_sel are 0,1,1 per pass; TRNG_Done in cycle 16; Go pulses during Busy ignored.
- P_TIMEOUT=8, Hash_done never asserted → reg clear strobes and TRNG_Err rise 9 cycles after Hash_Go, no TRNG_Done. A following INIT Go clears TRNG_Err and completes normally.
- P_TIMEOUT=8, Hash_done exactly in the expiry cycle → CAPT taken, TRNG_Done, TRNG_Err stays 0.
- Reset asserted in WAIT of pass 2 of COND_3 → next cycle all outputs 0, IDLE. A spurious Hash_done afterwards produces no en_reg_2.

Source files
------------

// File: rtl/trng_cond_sequencer.sv
// trng_cond_sequencer
//   Cycle-level controller for the TRNG conditioning datapath. A start request
//   selects either a register clear (INIT) or 1..3 chained SHA passes over the
//   raw entropy word. A watchdog bounds the time spent waiting for the SHA core.
//
// Ports
//   clk, Reset            clock, synchronous active-high reset
//   TRNG_Go, Op_Type      start request and operation (0=INIT, n=n hash passes)
//   TRNG_Done/Busy/Err    completion pulse, busy level, watchdog error level
//   mux1_sel, mux2_sel    message source selects (0 on the first pass)
//   Hash_Go, Hash_done    SHA core start pulse / completion
//   rst_reg_1, rst_reg_2  message / digest register clear strobes
//   en_reg_1, en_reg_2    message / digest register load enables
//
// All outputs decode registered state only.

module trng_cond_sequencer #(
  parameter int unsigned P_TIMEOUT  = 1023,
  parameter int unsigned P_TO_WIDTH = 10
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       TRNG_Go,
  input  logic [1:0] Op_Type,
  output logic       TRNG_Done,
  output logic       TRNG_Busy,
  output logic       TRNG_Err,
  output logic       mux1_sel,
  output logic       mux2_sel,
  output logic       Hash_Go,
  input  logic       Hash_done,
  output logic       rst_reg_1,
  output logic       rst_reg_2,
  output logic       en_reg_1,
  output logic       en_reg_2
);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLoad,
    StHash,
    StWait,
    StCapt,
    StDone
  } state_e;

  // Count value seen in the last permitted WAIT cycle.
  localparam logic [P_TO_WIDTH-1:0] WdLast = P_TO_WIDTH'(P_TIMEOUT - 1);

  state_e                  state_q, state_d;
  logic [1:0]              k_q, k_d;
  logic [1:0]              op_q, op_d;
  logic [P_TO_WIDTH-1:0]   wd_q, wd_d;
  logic                    err_q, err_d;
  // One-cycle register clear issued while returning to IDLE on a timeout.
  logic                    to_strobe_q, to_strobe_d;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      k_q         <= '0;
      op_q        <= '0;
      wd_q        <= '0;
      err_q       <= 1'b0;
      to_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      op_q        <= op_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      to_strobe_q <= to_strobe_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    op_d        = op_q;
    wd_d        = wd_q;
    err_d       = err_q;
    to_strobe_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (TRNG_Go) begin
          op_d    = Op_Type;
          k_d     = 2'd1;
          err_d   = 1'b0;
          state_d = (Op_Type == 2'd0) ? StClr : StLoad;
        end
      end
      StClr:  state_d = StDone;
      StLoad: state_d = StHash;
      StHash: begin
        wd_d    = '0;
        state_d = StWait;
      end
      StWait: begin
        // Completion takes priority over an expiring watchdog.
        if (Hash_done) begin
          state_d = StCapt;
        end else if (wd_q == WdLast) begin
          wd_d        = wd_q + 1'b1;
          err_d       = 1'b1;
          to_strobe_d = 1'b1;
          state_d     = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StCapt: begin
        if (k_q == op_q) begin
          state_d = StDone;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = StLoad;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic chained;
  assign chained = (k_q != 2'd1);

  always_comb begin
    TRNG_Done = 1'b0;
    TRNG_Busy = (state_q != StIdle);
    TRNG_Err  = err_q;
    mux1_sel  = 1'b0;
    mux2_sel  = 1'b0;
    Hash_Go   = 1'b0;
    rst_reg_1 = to_strobe_q;
    rst_reg_2 = to_strobe_q;
    en_reg_1  = 1'b0;
    en_reg_2  = 1'b0;
    unique case (state_q)
      StClr: begin
        rst_reg_1 = 1'b1;
        rst_reg_2 = 1'b1;
      end
      StLoad: begin
        en_reg_1 = 1'b1;
        mux1_sel = chained;
        mux2_sel = chained;
      end
      StHash: begin
        Hash_Go  = 1'b1;
        mux1_sel = chained;
        mux2_sel = chained;
      end
      StWait: begin
        mux1_sel = chained;
        mux2_sel = chained;
      end
      StCapt:  en_reg_2 = 1'b1;
      StDone:  TRNG_Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trng_cond_sequencer.sv
// Directed bench for trng_cond_sequencer. The whole run is planned up front:
// per-cycle stimulus and the expected output vector for every cycle are built
// from the operation timing rules (pass length L+3, watchdog length, error
// level lifetime), then applied and compared cycle by cycle. A few literal
// expectations pin key cycles independently of the planner.

module tb_trng_cond_sequencer;

  localparam int unsigned P_TIMEOUT = 8;
  localparam int NCYC = 110;
  localparam int NLIT = 20;

  // Output vector bit positions.
  localparam int B_DONE = 9, B_BUSY = 8, B_ERR = 7, B_M1 = 6, B_M2 = 5;
  localparam int B_HGO = 4, B_R1 = 3, B_R2 = 2, B_E1 = 1, B_E2 = 0;
  localparam logic [9:0] M_DONE = 10'(1) << B_DONE;
  localparam logic [9:0] M_BUSY = 10'(1) << B_BUSY;
  localparam logic [9:0] M_ERR  = 10'(1) << B_ERR;
  localparam logic [9:0] M_M1   = 10'(1) << B_M1;
  localparam logic [9:0] M_M2   = 10'(1) << B_M2;
  localparam logic [9:0] M_HGO  = 10'(1) << B_HGO;
  localparam logic [9:0] M_R1   = 10'(1) << B_R1;
  localparam logic [9:0] M_R2   = 10'(1) << B_R2;
  localparam logic [9:0] M_E1   = 10'(1) << B_E1;
  localparam logic [9:0] M_E2   = 10'(1) << B_E2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset, TRNG_Go, Hash_done;
  logic [1:0] Op_Type;
  logic       TRNG_Done, TRNG_Busy, TRNG_Err, mux1_sel, mux2_sel, Hash_Go;
  logic       rst_reg_1, rst_reg_2, en_reg_1, en_reg_2;

  trng_cond_sequencer #(
    .P_TIMEOUT (P_TIMEOUT),
    .P_TO_WIDTH(4)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .TRNG_Go  (TRNG_Go),
    .Op_Type  (Op_Type),
    .TRNG_Done(TRNG_Done),
    .TRNG_Busy(TRNG_Busy),
    .TRNG_Err (TRNG_Err),
    .mux1_sel (mux1_sel),
    .mux2_sel (mux2_sel),
    .Hash_Go  (Hash_Go),
    .Hash_done(Hash_done),
    .rst_reg_1(rst_reg_1),
    .rst_reg_2(rst_reg_2),
    .en_reg_1 (en_reg_1),
    .en_reg_2 (en_reg_2)
  );

  logic [9:0] act_v;
  assign act_v = {TRNG_Done, TRNG_Busy, TRNG_Err, mux1_sel, mux2_sel, Hash_Go,
                  rst_reg_1, rst_reg_2, en_reg_1, en_reg_2};

  logic [9:0] exp_v [NCYC];
  logic       go_v  [NCYC];
  logic       hd_v  [NCYC];
  logic       rst_v [NCYC];
  logic [1:0] op_v  [NCYC];
  int         err_start;

  int n_vec;
  int n_bad;
  int cur_cyc;
  bit running;

  // Hand-computed pins: {cycle, bit, value}.
  int   lit_c [NLIT] = '{6, 7, 7, 10, 10, 15, 16, 29, 29, 38,
                         50, 50, 50, 54, 55, 69, 70, 70, 84, 102};
  int   lit_b [NLIT] = '{B_R1, B_DONE, B_HGO, B_HGO, B_M1, B_E2, B_DONE, B_M1, B_M2, B_DONE,
                         B_ERR, B_R2, B_DONE, B_ERR, B_DONE, B_E2, B_DONE, B_ERR, B_BUSY, B_DONE};
  logic lit_v [NLIT] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                         1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic mark(input int c, input logic [9:0] m);
    if (c >= 0 && c < NCYC) exp_v[c] = exp_v[c] | m;
  endtask

  // The error level lasts from the timeout cycle through the cycle of the
  // next accepted Go (or reset).
  task automatic close_err(input int upto);
    if (err_start >= 0) begin
      for (int c = err_start; c <= upto && c < NCYC; c++) mark(c, M_ERR);
      err_start = -1;
    end
  endtask

  // Accepted Go in cycle c0. lat < 0 means Hash_done never arrives.
  task automatic schedule_op(input int c0, input int op, input int lat);
    int base;
    int h;
    logic [9:0] mx;
    close_err(c0);
    go_v[c0] = 1'b1;
    op_v[c0] = 2'(op);
    if (op == 0) begin
      mark(c0 + 1, M_BUSY | M_R1 | M_R2);
      mark(c0 + 2, M_BUSY | M_DONE);
    end else begin
      for (int p = 0; p < op; p++) begin
        mx   = (p != 0) ? (M_M1 | M_M2) : 10'd0;
        base = c0 + 1 + p * (lat + 3);
        h    = base + 1;
        mark(base, M_BUSY | M_E1 | mx);
        mark(h, M_BUSY | M_HGO | mx);
        if (lat < 0) begin
          for (int w = 1; w <= int'(P_TIMEOUT); w++) mark(h + w, M_BUSY | mx);
          mark(h + int'(P_TIMEOUT) + 1, M_R1 | M_R2);
          err_start = h + int'(P_TIMEOUT) + 1;
          break;
        end
        for (int w = 1; w <= lat; w++) mark(h + w, M_BUSY | mx);
        if (h + lat < NCYC) hd_v[h + lat] = 1'b1;
        mark(h + lat + 1, M_BUSY | M_E2);
        if (p == op - 1) mark(h + lat + 2, M_BUSY | M_DONE);
      end
    end
  endtask

  // Reset high in cycle rc: everything planned after it up to 'upto' vanishes.
  task automatic apply_reset(input int rc, input int upto);
    rst_v[rc] = 1'b1;
    close_err(rc);
    for (int c = rc + 1; c <= upto && c < NCYC; c++) begin
      exp_v[c] = '0;
      hd_v[c]  = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (running) begin
      n_vec++;
      if (act_v !== exp_v[cur_cyc]) begin
        n_bad++;
        $display("FAIL cycle %0d outputs {done,busy,err,m1,m2,hgo,r1,r2,e1,e2}: got %b want %b",
                 cur_cyc, act_v, exp_v[cur_cyc]);
      end
      for (int i = 0; i < NLIT; i++) begin
        if (lit_c[i] == cur_cyc) begin
          n_vec++;
          if (act_v[lit_b[i]] !== lit_v[i]) begin
            n_bad++;
            $display("FAIL pin cycle %0d bit %0d: got %b want %b",
                     cur_cyc, lit_b[i], act_v[lit_b[i]], lit_v[i]);
          end
        end
      end
    end
  end

  initial begin
    for (int c = 0; c < NCYC; c++) begin
      exp_v[c] = '0;
      go_v[c]  = 1'b0;
      hd_v[c]  = 1'b0;
      rst_v[c] = 1'b0;
      op_v[c]  = 2'(c % 4);  // Op_Type wanders while busy
    end
    err_start = -1;
    for (int c = 0; c < 3; c++) rst_v[c] = 1'b1;

    schedule_op(5, 0, 0);        // INIT
    schedule_op(8, 1, 4);        // COND_1, L=4, back-to-back after INIT
    go_v[12] = 1'b1;             // ignored while busy
    hd_v[9]  = 1'b1;             // Hash_done in LOAD: ignored
    hd_v[20] = 1'b1;             // Hash_done in IDLE: ignored
    schedule_op(22, 3, 2);       // COND_3, L=2
    go_v[25] = 1'b1;
    go_v[30] = 1'b1;
    go_v[38] = 1'b1;             // Go during DONE: ignored
    schedule_op(39, 2, -1);      // timeout on first pass
    schedule_op(53, 0, 0);       // INIT clears the error
    schedule_op(58, 1, 8);       // Hash_done in watchdog expiry cycle
    schedule_op(75, 3, 2);       // COND_3, reset in WAIT of pass 2
    apply_reset(83, 92);
    hd_v[84] = 1'b1;             // spurious completions after reset
    hd_v[85] = 1'b1;
    schedule_op(93, 2, 1);       // normal operation after reset
    close_err(NCYC - 1);

    n_vec     = 0;
    n_bad     = 0;
    cur_cyc   = 0;
    running   = 1'b0;
    Reset     = 1'b1;
    TRNG_Go   = 1'b0;
    Op_Type   = 2'd0;
    Hash_done = 1'b0;

    for (int n = 0; n < NCYC; n++) begin
      @(posedge clk);
      #1;
      cur_cyc   = n;
      Reset     = rst_v[n];
      TRNG_Go   = go_v[n];
      Op_Type   = op_v[n];
      Hash_done = hd_v[n];
      running   = 1'b1;
    end
    @(posedge clk);
    running = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
